// File: rtl/misr_response_reader.sv
// Compacts NUM_PATTERNS netlist responses into a MISR signature, then compares it against a golden value.
// Latency: a back-to-back source finishes a run NUM_PATTERNS cycles after start; done rises on the final transfer edge.
// Backpressure: resp_ready is high only while compacting and drops on the same edge as the final transfer.
//
// Ports:
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   start                 single-cycle pulse that begins a run (honoured in idle or done only)
//   resp_valid/resp_ready response handshake; resp_data is held by the source until taken
//   resp_data             netlist response vector
//   resp_mask             (MISR_XMASK_EN only) per-bit mask; masked bits compact as 0
//   expected              golden signature, sampled on the completing transfer
//   busy, done, pass      run status; pass is meaningful while done=1
//   signature, count      current MISR contents and responses accepted this run
// Optional feature macro: MISR_XMASK_EN adds resp_mask for X-masking of unknown outputs.
module misr_response_reader #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = 16'h1021,
  parameter logic [WIDTH-1:0] SEED         = 16'h0000,
  parameter int               NUM_PATTERNS = 4,
  localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp_data,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  input  logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {IDLE, COMPACT, DONE} state_t;

  state_t           state, state_n;
  logic             resp_ready_n, busy_n, done_n, pass_n;
  logic [WIDTH-1:0] signature_n;
  logic [CW-1:0]    count_n;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sig_step;
  logic             xfer;
  logic             last;

`ifdef MISR_XMASK_EN
  // Masked bits are unknown netlist outputs; force them to a known 0.
  assign din = resp_data & ~resp_mask;
`else
  assign din = resp_data;
`endif

  // One MISR step: shift left, fold the shifted-out MSB back through POLY, XOR in the response.
  assign sig_step = {signature[WIDTH-2:0], 1'b0}
                  ^ (signature[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                  ^ din;

  assign xfer = (state == COMPACT) && resp_valid && resp_ready;
  assign last = (count == CW'(NUM_PATTERNS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= SEED;
      count      <= '0;
    end else begin
      state      <= state_n;
      resp_ready <= resp_ready_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      signature  <= signature_n;
      count      <= count_n;
    end
  end

  always_comb begin
    state_n      = state;
    resp_ready_n = resp_ready;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    signature_n  = signature;
    count_n      = count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = COMPACT;
          signature_n  = SEED;
          count_n      = '0;
          busy_n       = 1'b1;
          resp_ready_n = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
        end
      end
      COMPACT: begin
        // start is deliberately not looked at here: a run cannot be restarted.
        if (xfer) begin
          signature_n = sig_step;
          count_n     = count + CW'(1);
          if (last) begin
            state_n      = DONE;
            resp_ready_n = 1'b0;
            busy_n       = 1'b0;
            done_n       = 1'b1;
            pass_n       = (sig_step == expected);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_misr_response_reader.sv
module tb_misr_response_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
`ifdef MISR_XMASK_EN
  logic [15:0] resp_mask;
`endif
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  misr_response_reader #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'h0000), .NUM_PATTERNS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef MISR_XMASK_EN
    .resp_mask  (resp_mask),
`endif
    .expected   (expected),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one response for one edge; resp_ready is high throughout COMPACT.
  task automatic send(input logic [15:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    step();
    resp_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ready"}, 32'(resp_ready), 32'h0);
    check({tag, ".busy"},  32'(busy),       32'h0);
    check({tag, ".done"},  32'(done),       32'h0);
    check({tag, ".pass"},  32'(pass),       32'h0);
    check({tag, ".sig"},   32'(signature),  32'h0);
    check({tag, ".count"}, 32'(count),      32'h0);
  endtask

  logic [15:0] basic_dat [4];
  logic [15:0] basic_sig [4];

  initial begin
    basic_dat = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
    basic_sig = '{16'h8000, 16'h1021, 16'h2042, 16'h4084};

    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 16'h0;
    expected   = 16'h4084;
`ifdef MISR_XMASK_EN
    resp_mask  = 16'h0;
`endif
    #12;
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Basic run, back-to-back source, pass case.
    do_start();
    check("start.busy",  32'(busy),       32'h1);
    check("start.ready", 32'(resp_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      send(basic_dat[i]);
      check($sformatf("basic.sig%0d", i), 32'(signature), 32'(basic_sig[i]));
      check($sformatf("basic.cnt%0d", i), 32'(count),     32'(i + 1));
    end
    check("basic.done",  32'(done),       32'h1);
    check("basic.pass",  32'(pass),       32'h1);
    check("basic.busy",  32'(busy),       32'h0);
    check("basic.ready", 32'(resp_ready), 32'h0);

    // Extra valid after done is not accepted.
    send(16'hFFFF);
    check("afterdone.ready", 32'(resp_ready), 32'h0);
    check("afterdone.sig",   32'(signature),  32'h4084);
    check("afterdone.count", 32'(count),      32'h4);
    step();
    check("hold.pass", 32'(pass), 32'h1);

    // Start in DONE: fresh run from SEED, done/pass cleared; fail case.
    expected = 16'h4085;
    do_start();
    check("restart.done", 32'(done),      32'h0);
    check("restart.pass", 32'(pass),      32'h0);
    check("restart.sig",  32'(signature), 32'h0);
    check("restart.cnt",  32'(count),     32'h0);
    for (int i = 0; i < 4; i++) send(basic_dat[i]);
    check("fail.done", 32'(done),      32'h1);
    check("fail.pass", 32'(pass),      32'h0);
    check("fail.sig",  32'(signature), 32'h4084);

    // Stalls: valid low every other cycle.
    expected = 16'h4084;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(basic_dat[i]);
      step();
      check($sformatf("stall.cnt%0d", i), 32'(count),     32'(i + 1));
      check($sformatf("stall.sig%0d", i), 32'(signature), 32'(basic_sig[i]));
    end
    check("stall.done", 32'(done), 32'h1);
    check("stall.pass", 32'(pass), 32'h1);

    // start during COMPACT is ignored, also when coincident with a transfer.
    do_start();
    send(16'h8000);
    do_start();
    check("midstart.cnt", 32'(count),     32'h1);
    check("midstart.sig", 32'(signature), 32'h8000);
    start = 1'b1;
    send(16'h0000);
    start = 1'b0;
    check("xferstart.cnt", 32'(count),     32'h2);
    check("xferstart.sig", 32'(signature), 32'h1021);

    // Abort mid-run with an asynchronous reset, checked before the next edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    step();
    rst = 1'b0;
    step();
    do_start();
    for (int i = 0; i < 4; i++) send(basic_dat[i]);
    check("abortrun.sig",  32'(signature), 32'h4084);
    check("abortrun.pass", 32'(pass),      32'h1);

    // X-masking: the FFFF response is fully masked only when the feature is built in.
    do_start();
    send(16'h8000);
`ifdef MISR_XMASK_EN
    resp_mask = 16'hFFFF;
`endif
    send(16'hFFFF);
`ifdef MISR_XMASK_EN
    resp_mask = 16'h0000;
`endif
    send(16'h0000);
    send(16'h0000);
`ifdef MISR_XMASK_EN
    check("xmask.sig",  32'(signature), 32'h4084);
    check("xmask.pass", 32'(pass),      32'h1);
`else
    check("nomask.sig",  32'(signature), 32'h8F1B);
    check("nomask.pass", 32'(pass),      32'h0);
`endif
    check("xmask.done", 32'(done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
